// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer: host-side command initiator for LCD_CTRL.
// Fetches opcodes from a synchronous command ROM and issues them over the
// cmd/cmd_valid/busy handshake. After the WRITE opcode, or after the last
// ROM entry, it waits for done and then raises finish.
// Optional feature macro: LCD_ISSUER_WDOG_EN adds a watchdog that forces FIN
// and raises timeout when ISSUE/WAITD stall for 2**WDOG_W-1 cycles.
module lcd_cmd_issuer #(
    parameter int CMD_N  = 45,
    parameter int ADDR_W = 6,
    parameter int WDOG_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        CMD_ROM_Q,
    output logic              CMD_ROM_EN,
    output logic [ADDR_W-1:0] CMD_ROM_A,
    input  logic              busy,
    input  logic              done,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_cnt,
    output logic              finish,
    output logic              timeout
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, GUARD, WAITD, FIN} state_t;

    state_t            state, state_nxt;
    logic              rom_en_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [2:0]        cmd_nxt;
    logic              valid_nxt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              finish_nxt;
    logic              accept;

    assign accept = (state == ISSUE) && cmd_valid && !busy;

`ifdef LCD_ISSUER_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic              timeout_nxt;

    // Watchdog and sticky timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            wdog    <= wdog_nxt;
            timeout <= timeout_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            CMD_ROM_EN <= 1'b1;
            CMD_ROM_A  <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            cmd_cnt    <= '0;
            finish     <= 1'b0;
        end else begin
            state      <= state_nxt;
            CMD_ROM_EN <= rom_en_nxt;
            CMD_ROM_A  <= addr_nxt;
            cmd        <= cmd_nxt;
            cmd_valid  <= valid_nxt;
            cmd_cnt    <= cnt_nxt;
            finish     <= finish_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        rom_en_nxt = 1'b1;
        addr_nxt   = CMD_ROM_A;
        cmd_nxt    = cmd;
        valid_nxt  = 1'b0;
        cnt_nxt    = cmd_cnt;
        finish_nxt = finish;
`ifdef LCD_ISSUER_WDOG_EN
        wdog_nxt    = wdog;
        timeout_nxt = timeout;
`endif
        case (state)
            IDLE, FIN: begin
                if (start) begin
                    state_nxt  = FETCH;
                    rom_en_nxt = 1'b0;
                    addr_nxt   = '0;
                    cnt_nxt    = '0;
                    finish_nxt = 1'b0;
`ifdef LCD_ISSUER_WDOG_EN
                    wdog_nxt    = '0;
                    timeout_nxt = 1'b0;
`endif
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                cmd_nxt   = CMD_ROM_Q;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    if (cmd_cnt != ADDR_W'(CMD_N)) cnt_nxt = cmd_cnt + 1'b1;
                    if (CMD_ROM_A != '1) addr_nxt = CMD_ROM_A + 1'b1;
                    if (cmd == 3'd0 || CMD_ROM_A == ADDR_W'(CMD_N - 1))
                        state_nxt = WAITD;
                    else
                        state_nxt = GUARD;
`ifdef LCD_ISSUER_WDOG_EN
                    wdog_nxt = '0;
`endif
                end else begin
                    valid_nxt = !busy;
                end
            end
            GUARD: begin
                state_nxt  = FETCH;
                rom_en_nxt = 1'b0;
            end
            WAITD: begin
                if (done) begin
                    state_nxt  = FIN;
                    finish_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef LCD_ISSUER_WDOG_EN
        // Stall detection overrides the normal ISSUE/WAITD progression
        if ((state == ISSUE && !accept) || (state == WAITD && !done)) begin
            if (wdog == WDOG_LAST) begin
                timeout_nxt = 1'b1;
                finish_nxt  = 1'b1;
                valid_nxt   = 1'b0;
                state_nxt   = FIN;
            end else begin
                wdog_nxt = wdog + 1'b1;
            end
        end
`endif
    end

endmodule
